// File: rtl/lcd_refresh_driver_pkg.sv
// Shared definitions for the HD44780 16x2 refresh driver: command bytes,
// step counts, state types and the init-command lookup.
package lcd_pkg;

    // HD44780 command bytes used during init and at each line start
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    // Number of init writes, and writes per refresh frame (2 cursor moves + 32 chars)
    localparam int INIT_STEPS  = 4;
    localparam int FRAME_STEPS = 34;

    // Top-level sequencer: wait for panel power-up, latch a write, run its bus timing
    typedef enum logic [1:0] {
        SEQ_PWRUP,
        SEQ_LOAD,
        SEQ_WRITE
    } lcd_seq_state_e;

    // Bus timing for one write: idle, RS/DATA setup, enable pulse, execution wait
    typedef enum logic [1:0] {
        WC_IDLE,
        WC_SETUP,
        WC_EN_HI,
        WC_WAIT
    } lcd_wc_state_e;

    // Command byte issued at each init step, in panel bring-up order
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] cmd;
        case (step)
            2'd0:    cmd = LCD_FUNC_SET;
            2'd1:    cmd = LCD_DISP_ON;
            2'd2:    cmd = LCD_CLEAR;
            default: cmd = LCD_ENTRY;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_refresh_driver_if.sv
// Signal bundle between the refresh driver and its surroundings: the
// character-source handshake, status flags and the LCD pad signals.
interface lcd_refresh_driver_if;

    logic [7:0] lcd_ascii;
    logic [4:0] lcd_index;
    logic       init_done;
    logic       frame_done;
    logic       LCD_ON;
    logic       LCD_BLON;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;
    logic [7:0] LCD_DATA;

    // The driver side: samples the character, drives position, flags and pads
    modport master (
        input  lcd_ascii,
        output lcd_index, init_done, frame_done,
        output LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS, LCD_DATA
    );

    // The environment side: supplies the character for the requested position
    modport slave (
        output lcd_ascii,
        input  lcd_index, init_done, frame_done,
        input  LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS, LCD_DATA
    );

endinterface

// File: rtl/lcd_refresh_driver_write_cycle.sv
// Bus timing for a single HD44780 write. A one-cycle start kicks off the
// setup delay, the enable pulse and the execution wait; done is high in the
// last wait cycle so the caller can load the next write with no idle gap.
module lcd_write_cycle
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 16,
    parameter int CMD_CYC   = 2000,
    parameter int CLR_CYC   = 82000
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic long_wait_i,
    output logic en_o,
    output logic done_o
);

    localparam int MAX_AB  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_CD  = (CMD_CYC > CLR_CYC) ? CMD_CYC : CLR_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);

    lcd_wc_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q;
    logic [CW-1:0] wait_last;

    assign wait_last = long_wait_i ? CLR_LAST : CMD_LAST;
    assign en_o      = en_q;

    // State and phase counter; the enable is registered from the next state so
    // the pad sees a clean strobe that is high exactly while in EN_HI
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WC_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= (state_d == WC_EN_HI);
        end
    end

    // Each phase counts up from zero and moves on at its parameter minus one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        done_o  = 1'b0;
        case (state_q)
            WC_IDLE: begin
                cnt_d = '0;
                if (start_i) state_d = WC_SETUP;
            end
            WC_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = WC_EN_HI;
                    cnt_d   = '0;
                end
            end
            WC_EN_HI: begin
                if (cnt_q == EN_LAST) begin
                    state_d = WC_WAIT;
                    cnt_d   = '0;
                end
            end
            WC_WAIT: begin
                if (cnt_q == wait_last) begin
                    done_o  = 1'b1;
                    state_d = WC_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/lcd_refresh_driver.sv
// Step sequencer for the DE2-115 16x2 character LCD. After a power-up delay
// it sends the four init commands once, then rewrites the whole screen
// forever: cursor to line 1, 16 characters, cursor to line 2, 16 characters.
module lcd_refresh_driver
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC = 750000,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 16,
    parameter int CMD_CYC   = 2000,
    parameter int CLR_CYC   = 82000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    lcd_refresh_driver_if.master bus
);

    localparam int PW = $clog2(PWRUP_CYC + 1);
    localparam logic [PW-1:0] PWRUP_LAST = PW'(PWRUP_CYC - 1);
    localparam logic [5:0]    LAST_INIT  = 6'(INIT_STEPS - 1);
    localparam logic [5:0]    LINE2_STEP = 6'(FRAME_STEPS / 2);
    localparam logic [5:0]    LAST_FRAME = 6'(FRAME_STEPS - 1);

    lcd_seq_state_e state_q, state_d;
    logic [PW-1:0]  pwr_cnt_q, pwr_cnt_d;
    logic [5:0]     step_q;
    logic [4:0]     index_q;
    logic           init_done_q;
    logic           frame_done_q;
    logic           rs_q;
    logic [7:0]     data_q;
    logic           long_q;

    logic           wc_start;
    logic           wc_done;
    logic           wc_en;
    logic           advance;
    logic           load_rs;
    logic [7:0]     load_data;

    lcd_write_cycle #(
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .CMD_CYC   (CMD_CYC),
        .CLR_CYC   (CLR_CYC)
    ) u_write_cycle (
        .clk         (CLOCK_50),
        .rst         (RESET),
        .start_i     (wc_start),
        .long_wait_i (long_q),
        .en_o        (wc_en),
        .done_o      (wc_done)
    );

    assign advance = (state_q == SEQ_WRITE) && wc_done;

    assign bus.lcd_index  = index_q;
    assign bus.init_done  = init_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.LCD_ON     = 1'b1;
    assign bus.LCD_BLON   = 1'b1;
    assign bus.LCD_RW     = 1'b0;
    assign bus.LCD_EN     = wc_en;
    assign bus.LCD_RS     = rs_q;
    assign bus.LCD_DATA   = data_q;

    // Sequencer state and power-up counter
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q   <= SEQ_PWRUP;
            pwr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
        end
    end

    // Power-up wait, then alternate one LOAD cycle with one timed bus write
    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = pwr_cnt_q;
        wc_start  = 1'b0;
        case (state_q)
            SEQ_PWRUP: begin
                if (pwr_cnt_q == PWRUP_LAST) state_d = SEQ_LOAD;
                else                         pwr_cnt_d = pwr_cnt_q + PW'(1);
            end
            SEQ_LOAD: begin
                wc_start = 1'b1;
                state_d  = SEQ_WRITE;
            end
            SEQ_WRITE: begin
                if (wc_done) state_d = SEQ_LOAD;
            end
            default: state_d = SEQ_PWRUP;
        endcase
    end

    // What the current step puts on the bus: an init command, a cursor move,
    // or the character the source returns for the current position
    always_comb begin
        load_rs   = 1'b0;
        load_data = 8'h00;
        if (!init_done_q) begin
            load_data = init_cmd(step_q[1:0]);
        end else if (step_q == 6'd0) begin
            load_data = LCD_LINE1;
        end else if (step_q == LINE2_STEP) begin
            load_data = LCD_LINE2;
        end else begin
            load_rs   = 1'b1;
            load_data = bus.lcd_ascii;
        end
    end

    // RS/DATA are captured once in LOAD and held through the whole write, so
    // the source may change freely while the panel is being strobed
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            long_q <= 1'b0;
        end else if (state_q == SEQ_LOAD) begin
            rs_q   <= load_rs;
            data_q <= load_data;
            long_q <= !load_rs && (load_data == LCD_CLEAR);
        end
    end

    // Step, screen position and flags move on the edge that ends a write;
    // the position only steps after a character, so command steps already
    // present the position of the character that follows them
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            step_q       <= '0;
            index_q      <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= advance && init_done_q && (step_q == LAST_FRAME);
            if (advance) begin
                if (!init_done_q) begin
                    if (step_q == LAST_INIT) begin
                        init_done_q <= 1'b1;
                        step_q      <= '0;
                    end else begin
                        step_q <= step_q + 6'd1;
                    end
                end else begin
                    if (step_q == LAST_FRAME) step_q <= '0;
                    else                      step_q <= step_q + 6'd1;
                    if (rs_q) index_q <= index_q + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_refresh_driver.sv
// Self-checking bench for lcd_refresh_driver with shortened timing.
// Every write on the bus is captured at its enable rise and compared with a
// reference list of the writes the panel should receive since reset.
module tb_lcd_refresh_driver;

    localparam int PWRUP_CYC = 20;
    localparam int SETUP_CYC = 2;
    localparam int EN_CYC    = 4;
    localparam int CMD_CYC   = 10;
    localparam int CLR_CYC   = 30;
    localparam int BOUND     = 2000;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;

    lcd_refresh_driver_if bus();

    lcd_refresh_driver #(
        .PWRUP_CYC (PWRUP_CYC),
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .CMD_CYC   (CMD_CYC),
        .CLR_CYC   (CLR_CYC)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    // 100 MHz bench clock; only cycle counts matter here
    always #5 CLOCK_50 = ~CLOCK_50;

    int         numChecks = 0;
    int         numFails  = 0;
    bit         srcEcho   = 1'b1;
    logic [7:0] tbAscii   = 8'h20;
    bit         pendingZero = 1'b0;
    bit         aborted     = 1'b0;
    int         writeNum    = 0;

    // Character source: either echoes 0x40 + position, or a bench-driven byte
    always_comb bus.lcd_ascii = srcEcho ? 8'(32'h40 + 32'(bus.lcd_index)) : tbAscii;

    // Free-running cycle counter, stepped on the active edge
    int cycleCount = 0;
    always @(posedge CLOCK_50) cycleCount <= cycleCount + 1;

    // Watch frame_done: count pulses, remember when, and catch any wider pulse
    int   pulseCount = 0;
    int   lastPulseCycle = 0;
    int   doublePulse = 0;
    logic prevFd = 1'b0;
    always @(negedge CLOCK_50) begin
        if (bus.frame_done === 1'b1) begin
            pulseCount++;
            lastPulseCycle = cycleCount;
            if (prevFd === 1'b1) doublePulse++;
        end
        prevFd = bus.frame_done;
    end

    // Reference: the n-th write since reset as {RS, DATA}
    function automatic logic [8:0] modelWrite(input int n, input bit echo, input logic [7:0] held);
        int k;
        int pos;
        case (n)
            0: return {1'b0, 8'h38};
            1: return {1'b0, 8'h0C};
            2: return {1'b0, 8'h01};
            3: return {1'b0, 8'h06};
            default: ;
        endcase
        k = (n - 4) % 34;
        if (k == 0)  return {1'b0, 8'h80};
        if (k == 17) return {1'b0, 8'hC0};
        pos = (k < 17) ? k - 1 : k - 2;
        return {1'b1, echo ? 8'(32'h40 + pos) : held};
    endfunction

    // Reference: screen position presented during the n-th write
    function automatic logic [4:0] modelIndex(input int n);
        int k;
        if (n < 4) return 5'd0;
        k = (n - 4) % 34;
        if (k == 0)  return 5'd0;
        if (k <= 16) return 5'(k - 1);
        if (k == 17) return 5'd16;
        return 5'(k - 2);
    endfunction

    // Reference: enable-low cycles before the n-th write's enable rise
    function automatic int modelGap(input int n);
        if (n == 0) return PWRUP_CYC + 1 + SETUP_CYC;
        if (n == 3) return CLR_CYC + 1 + SETUP_CYC;
        return CMD_CYC + 1 + SETUP_CYC;
    endfunction

    // Observe one bus write: low samples before the rise, bus at the rise, high samples
    task automatic captureWrite(output bit ok, output logic capRs, output logic [7:0] capData,
                                output logic [4:0] capIdx, output logic capInit,
                                output int gap, output int width, output int riseCycle);
        bit seen;
        ok = 1'b0; capRs = 1'b0; capData = 8'h00; capIdx = 5'd0; capInit = 1'b0;
        gap = pendingZero ? 1 : 0; width = 0; riseCycle = 0;
        if (aborted) return;
        seen = 1'b0;
        for (int c = 0; c < BOUND && !seen; c++) begin
            @(negedge CLOCK_50);
            if (bus.LCD_EN === 1'b1) seen = 1'b1;
            else gap++;
        end
        if (!seen) begin aborted = 1'b1; return; end
        capRs = bus.LCD_RS; capData = bus.LCD_DATA; capIdx = bus.lcd_index;
        capInit = bus.init_done; riseCycle = cycleCount;
        width = 1;
        seen = 1'b0;
        for (int c = 0; c < BOUND && !seen; c++) begin
            @(negedge CLOCK_50);
            if (bus.LCD_EN !== 1'b1) seen = 1'b1;
            else width++;
        end
        if (!seen) begin aborted = 1'b1; return; end
        pendingZero = 1'b1;
        ok = 1'b1;
    endtask

    task automatic releaseReset();
        @(posedge CLOCK_50);
        #1 RESET = 1'b0;
        pendingZero = 1'b0;
        writeNum = 0;
    endtask

    task automatic test_reset();
        bit ok; logic rs; logic [7:0] d; logic [4:0] idx; logic ini; int gap, width, rc;
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        numChecks++; if (bus.LCD_EN !== 1'b0) begin numFails++; $display("[TB] FAIL reset_en: got %b expected 0", bus.LCD_EN); end
        numChecks++; if (bus.LCD_RS !== 1'b0) begin numFails++; $display("[TB] FAIL reset_rs: got %b expected 0", bus.LCD_RS); end
        numChecks++; if (bus.LCD_DATA !== 8'h00) begin numFails++; $display("[TB] FAIL reset_data: got %h expected 00", bus.LCD_DATA); end
        numChecks++; if (bus.lcd_index !== 5'd0) begin numFails++; $display("[TB] FAIL reset_index: got %0d expected 0", bus.lcd_index); end
        numChecks++; if (bus.init_done !== 1'b0) begin numFails++; $display("[TB] FAIL reset_init_done: got %b expected 0", bus.init_done); end
        numChecks++; if (bus.frame_done !== 1'b0) begin numFails++; $display("[TB] FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
        numChecks++; if ({bus.LCD_ON, bus.LCD_BLON, bus.LCD_RW} !== 3'b110) begin numFails++; $display("[TB] FAIL const_pins: got %b expected 110", {bus.LCD_ON, bus.LCD_BLON, bus.LCD_RW}); end
        releaseReset();
        captureWrite(ok, rs, d, idx, ini, gap, width, rc);
        numChecks++; if (!ok) begin numFails++; $display("[TB] FAIL first_write_timeout: got no enable pulse expected one"); end
        numChecks++; if (gap !== PWRUP_CYC + 1 + SETUP_CYC) begin numFails++; $display("[TB] FAIL first_rise_delay: got %0d expected %0d", gap, PWRUP_CYC + 1 + SETUP_CYC); end
        numChecks++; if ({rs, d} !== {1'b0, 8'h38}) begin numFails++; $display("[TB] FAIL first_write: got rs=%b data=%h expected rs=0 data=38", rs, d); end
        numChecks++; if (width !== EN_CYC) begin numFails++; $display("[TB] FAIL first_en_width: got %0d expected %0d", width, EN_CYC); end
        writeNum++;
    endtask

    task automatic test_init_order();
        bit ok; logic rs; logic [7:0] d; logic [4:0] idx; logic ini; int gap, width, rc;
        logic [8:0] expW;
        for (int i = 1; i < 4; i++) begin
            captureWrite(ok, rs, d, idx, ini, gap, width, rc);
            expW = modelWrite(writeNum, 1'b1, 8'h00);
            numChecks++; if (!ok) begin numFails++; $display("[TB] FAIL init_timeout: write %0d got no pulse expected one", writeNum); end
            numChecks++; if ({rs, d} !== expW) begin numFails++; $display("[TB] FAIL init_write: write %0d got %h expected %h", writeNum, {rs, d}, expW); end
            numChecks++; if (gap !== modelGap(writeNum)) begin numFails++; $display("[TB] FAIL init_gap: write %0d got %0d expected %0d", writeNum, gap, modelGap(writeNum)); end
            numChecks++; if (width !== EN_CYC) begin numFails++; $display("[TB] FAIL init_en_width: write %0d got %0d expected %0d", writeNum, width, EN_CYC); end
            numChecks++; if (ini !== 1'b0) begin numFails++; $display("[TB] FAIL init_done_early: write %0d got %b expected 0", writeNum, ini); end
            writeNum++;
        end
    endtask

    task automatic test_frame();
        bit ok; logic rs; logic [7:0] d; logic [4:0] idx; logic ini; int gap, width, rc;
        logic [8:0] expW;
        for (int i = 0; i < 34; i++) begin
            captureWrite(ok, rs, d, idx, ini, gap, width, rc);
            expW = modelWrite(writeNum, 1'b1, 8'h00);
            numChecks++; if (!ok) begin numFails++; $display("[TB] FAIL frame_timeout: write %0d got no pulse expected one", writeNum); end
            numChecks++; if ({rs, d} !== expW) begin numFails++; $display("[TB] FAIL frame_write: write %0d got %h expected %h", writeNum, {rs, d}, expW); end
            numChecks++; if (idx !== modelIndex(writeNum)) begin numFails++; $display("[TB] FAIL frame_index: write %0d got %0d expected %0d", writeNum, idx, modelIndex(writeNum)); end
            numChecks++; if (gap !== modelGap(writeNum)) begin numFails++; $display("[TB] FAIL frame_gap: write %0d got %0d expected %0d", writeNum, gap, modelGap(writeNum)); end
            numChecks++; if (width !== EN_CYC) begin numFails++; $display("[TB] FAIL frame_en_width: write %0d got %0d expected %0d", writeNum, width, EN_CYC); end
            numChecks++; if (ini !== 1'b1) begin numFails++; $display("[TB] FAIL frame_init_done: write %0d got %b expected 1", writeNum, ini); end
            writeNum++;
        end
        numChecks++; if (pulseCount !== 0) begin numFails++; $display("[TB] FAIL frame_done_early: got %0d pulses expected 0", pulseCount); end
    endtask

    task automatic test_back_to_back();
        bit ok; logic rs; logic [7:0] d; logic [4:0] idx; logic ini; int gap, width, rc;
        logic [8:0] expW;
        for (int i = 0; i < 35; i++) begin
            captureWrite(ok, rs, d, idx, ini, gap, width, rc);
            expW = modelWrite(writeNum, 1'b1, 8'h00);
            numChecks++; if (!ok) begin numFails++; $display("[TB] FAIL b2b_timeout: write %0d got no pulse expected one", writeNum); end
            numChecks++; if ({rs, d} !== expW) begin numFails++; $display("[TB] FAIL b2b_write: write %0d got %h expected %h", writeNum, {rs, d}, expW); end
            numChecks++; if (idx !== modelIndex(writeNum)) begin numFails++; $display("[TB] FAIL b2b_index: write %0d got %0d expected %0d", writeNum, idx, modelIndex(writeNum)); end
            numChecks++; if (gap !== modelGap(writeNum)) begin numFails++; $display("[TB] FAIL b2b_gap: write %0d got %0d expected %0d", writeNum, gap, modelGap(writeNum)); end
            numChecks++; if (ini !== 1'b1) begin numFails++; $display("[TB] FAIL b2b_init_done: write %0d got %b expected 1", writeNum, ini); end
            if (i == 0 || i == 34) begin
                numChecks++; if (pulseCount !== (i == 0 ? 1 : 2)) begin numFails++; $display("[TB] FAIL frame_done_count: got %0d expected %0d", pulseCount, (i == 0 ? 1 : 2)); end
                numChecks++; if (rc - lastPulseCycle !== 1 + SETUP_CYC) begin numFails++; $display("[TB] FAIL frame_done_timing: got %0d expected %0d", rc - lastPulseCycle, 1 + SETUP_CYC); end
            end
            writeNum++;
        end
        numChecks++; if (doublePulse !== 0) begin numFails++; $display("[TB] FAIL frame_done_width: got %0d long pulses expected 0", doublePulse); end
    endtask

    task automatic test_toggle();
        bit seen;
        logic [7:0] held;
        logic [8:0] expW;
        srcEcho = 1'b0;
        for (int w = 0; w < 8; w++) begin
            if (aborted) break;
            held = 8'($urandom_range(32, 126));
            tbAscii = held;
            expW = modelWrite(writeNum, 1'b0, held);
            seen = 1'b0;
            for (int c = 0; c < BOUND && !seen; c++) begin
                @(negedge CLOCK_50);
                if (bus.LCD_EN === 1'b1) seen = 1'b1;
            end
            numChecks++; if (!seen) begin numFails++; aborted = 1'b1; $display("[TB] FAIL toggle_timeout: got no pulse expected one"); end
            if (!seen) break;
            numChecks++; if ({bus.LCD_RS, bus.LCD_DATA} !== expW) begin numFails++; $display("[TB] FAIL toggle_write: write %0d got %h expected %h", writeNum, {bus.LCD_RS, bus.LCD_DATA}, expW); end
            // scramble the source through EN_HI and the first part of WAIT
            for (int c = 0; c < EN_CYC + 5; c++) begin
                tbAscii = 8'($urandom);
                @(negedge CLOCK_50);
                numChecks++; if ({bus.LCD_RS, bus.LCD_DATA} !== expW) begin numFails++; $display("[TB] FAIL toggle_hold: write %0d cycle %0d got %h expected %h", writeNum, c, {bus.LCD_RS, bus.LCD_DATA}, expW); end
            end
            writeNum++;
        end
        srcEcho = 1'b1;
    endtask

    task automatic test_reset_mid_en();
        bit seen;
        bit ok; logic rs; logic [7:0] d; logic [4:0] idx; logic ini; int gap, width, rc;
        seen = 1'b0;
        for (int c = 0; c < BOUND && !seen && !aborted; c++) begin
            @(negedge CLOCK_50);
            if (bus.LCD_EN === 1'b1 && bus.LCD_RS === 1'b1) seen = 1'b1;
        end
        numChecks++; if (!seen) begin numFails++; $display("[TB] FAIL midreset_timeout: got no character pulse expected one"); end
        @(negedge CLOCK_50);
        numChecks++; if (bus.LCD_EN !== 1'b1) begin numFails++; $display("[TB] FAIL midreset_pre_en: got %b expected 1", bus.LCD_EN); end
        #2 RESET = 1'b1;
        #1;
        numChecks++; if (bus.LCD_EN !== 1'b0) begin numFails++; $display("[TB] FAIL midreset_en: got %b expected 0", bus.LCD_EN); end
        numChecks++; if (bus.LCD_RS !== 1'b0) begin numFails++; $display("[TB] FAIL midreset_rs: got %b expected 0", bus.LCD_RS); end
        numChecks++; if (bus.LCD_DATA !== 8'h00) begin numFails++; $display("[TB] FAIL midreset_data: got %h expected 00", bus.LCD_DATA); end
        numChecks++; if ({bus.init_done, bus.lcd_index} !== 6'd0) begin numFails++; $display("[TB] FAIL midreset_flags: got %b expected 000000", {bus.init_done, bus.lcd_index}); end
        repeat (2) @(negedge CLOCK_50);
        aborted = 1'b0;
        releaseReset();
        captureWrite(ok, rs, d, idx, ini, gap, width, rc);
        numChecks++; if (!ok) begin numFails++; $display("[TB] FAIL restart_timeout: got no pulse expected one"); end
        numChecks++; if (gap !== PWRUP_CYC + 1 + SETUP_CYC) begin numFails++; $display("[TB] FAIL restart_delay: got %0d expected %0d", gap, PWRUP_CYC + 1 + SETUP_CYC); end
        numChecks++; if ({rs, d} !== {1'b0, 8'h38}) begin numFails++; $display("[TB] FAIL restart_write: got rs=%b data=%h expected rs=0 data=38", rs, d); end
        numChecks++; if (width !== EN_CYC) begin numFails++; $display("[TB] FAIL restart_en_width: got %0d expected %0d", width, EN_CYC); end
    endtask

    // Scenarios run back to back from one reset, then a mid-write reset
    initial begin
        $display("[TB] starting lcd_refresh_driver bench");
        test_reset();
        test_init_order();
        test_frame();
        test_back_to_back();
        test_toggle();
        test_reset_mid_en();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/lcd_refresh_driver.md
# lcd_refresh_driver

Sequencer and bus-timing engine for the DE2-115 16x2 HD44780 character LCD. It sits directly downstream of the combinational character source, such as the character/location formatter. It drives a 5-bit screen position (`lcd_index`) to that source and samples the returned ASCII byte. It then initialises the panel once and rewrites all 32 characters continuously, generating `LCD_EN`/`LCD_RS`/`LCD_DATA` with HD44780 setup, pulse-width and execution delays at 50 MHz.

## Interface
- `PWRUP_CYC`, 750000: cycles of idle after reset before the first write (15 ms).
- `SETUP_CYC`, 2: cycles from `LCD_RS`/`LCD_DATA` valid to `LCD_EN` rise.
- `EN_CYC`, 16: cycles `LCD_EN` is held high (320 ns).
- `CMD_CYC`, 2000: wait cycles after `LCD_EN` falls, for every write except clear (40 us).
- `CLR_CYC`, 82000: wait cycles after the clear command (1.64 ms).
- `CLOCK_50`, in, 1: single clock. The design has one clock; reset is asynchronous and active-high.
- `RESET`, in, 1: asynchronous, active-high reset.
- `lcd_ascii`, in, 8: character for the current `lcd_index`, supplied combinationally by the source.
- `lcd_index`, out, 5: registered screen position. Values 0–15 are line 1 and 16–31 are line 2.
- `init_done`, out, 1: level; set after the 4th init write completes.
- `frame_done`, out, 1: one-cycle pulse at the end of each 34-write frame.
- `LCD_ON`, out, 1: constant 1.
- `LCD_BLON`, out, 1: constant 1.
- `LCD_RW`, out, 1: constant 0 (write only).
- `LCD_EN`, out, 1: enable strobe.
- `LCD_RS`, out, 1: 0 = command, 1 = data.
- `LCD_DATA`, out, 8: bus value. The top level connects it to the inout pad; it is always driven because `LCD_RW` = 0.

## Operation
- Reset values: `LCD_EN`=0, `LCD_RS`=0, `LCD_DATA`=0, `lcd_index`=0, `init_done`=0, `frame_done`=0. The state machine is in PWRUP and all counters are 0.
- States: PWRUP → LOAD → SETUP → EN_HI → WAIT → LOAD …
  - PWRUP: counts `PWRUP_CYC` cycles, then goes to LOAD at init step 0.
  - LOAD (1 cycle): registers `LCD_RS` and `LCD_DATA`. For a command, `LCD_DATA` = the constant. For a character, `LCD_DATA` = `lcd_ascii` and `LCD_RS` = 1.
  - SETUP: `SETUP_CYC` cycles with `LCD_EN`=0.
  - EN_HI: `EN_CYC` cycles with `LCD_EN`=1.
  - WAIT: `LCD_EN`=0 for `CLR_CYC` cycles if the write was 0x01, otherwise `CMD_CYC` cycles. The step then advances.
- Init steps, in order: 0x38, 0x0C, 0x01, 0x06, all with RS=0.
  - After the last init step: `init_done`←1, and the block enters refresh step 0.
  - Init is never repeated except after reset.
- Refresh steps (34 per frame):
  - Step 0: command 0x80.
  - Steps 1–16: characters for `lcd_index` 0–15.
  - Step 17: command 0xC0.
  - Steps 18–33: characters for `lcd_index` 16–31.
  - After step 33, `frame_done` pulses and the block wraps to step 0 indefinitely.
- `lcd_index` is updated on the step-advance edge. It therefore holds the next character's position for at least the whole LOAD cycle.
- During command steps, `lcd_index` holds the position of the next character to be written.
- `LCD_RS` and `LCD_DATA` are stable from the end of LOAD through the end of WAIT. Changes on `lcd_ascii` outside LOAD are ignored.
- Source changes mid-frame appear at the next sampled position. No frame-level coherence is provided.
- Reset mid-operation takes effect immediately (asynchronous), including mid-EN_HI: `LCD_EN` drops in the same cycle. After reset is released, the full sequence restarts from PWRUP.

## Timing
- Cycles per write: 1 + `SETUP_CYC` + `EN_CYC` + WAIT cycles.
- With defaults, each character or command takes 2019 cycles. One frame is 68,646 cycles ≈ 1.37 ms, about 728 frames per second.
- First `LCD_EN` rise occurs `PWRUP_CYC` + 1 + `SETUP_CYC` cycles after `RESET` deasserts.
- `frame_done` is asserted for one cycle, in the cycle after the last WAIT cycle of step 33. That is the same cycle the block enters LOAD for step 0.
- All counters are sized for the largest parameter; counting is up with a compare to parameter−1.

## Structure
- Package `lcd_pkg`:
  - command constants: `LCD_FUNC_SET`=8'h38, `LCD_DISP_ON`=8'h0C, `LCD_CLEAR`=8'h01, `LCD_ENTRY`=8'h06, `LCD_LINE1`=8'h80, `LCD_LINE2`=8'hC0;
  - state enum;
  - `INIT_STEPS`=4, `FRAME_STEPS`=34.
- Sub-module `lcd_write_cycle`: handles the SETUP/EN_HI/WAIT timing for one write, with a `start`/`done` handshake and a `long_wait` select.
- The top level holds the step sequencer, `lcd_index` and the flags.

## Test plan
All scenarios use `PWRUP_CYC`=20, `SETUP_CYC`=2, `EN_CYC`=4, `CMD_CYC`=10, `CLR_CYC`=30.

- Reset, then release → `LCD_EN` stays 0 for 23 cycles. The first pulse has RS=0 and DATA=0x38, and `LCD_EN` stays high for exactly 4 cycles.
- Init order → writes are 0x38, 0x0C, 0x01, 0x06. The EN-fall to next-EN-rise gap is 33 cycles after 0x01 and 13 cycles otherwise. `init_done` rises after 0x06.
- Source returns 8'h40+`lcd_index` → the frame writes 0x80, then 0x40..0x4F with RS=1, then 0xC0, then 0x50..0x5F. `frame_done` pulses once after the 34th write.
- Run two frames → the second frame starts with 0x80 and issues no init commands; `init_done` stays 1.
- Toggle `lcd_ascii` during EN_HI and WAIT → `LCD_DATA` does not change until the next LOAD.
- Assert `RESET` mid-EN_HI → `LCD_EN`, `LCD_RS` and `LCD_DATA` go to 0 in the same cycle. After release, the 20-cycle power-up wait and 0x38 repeat.
